// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and a saturating counter helper for the
// program loader and its byte buffer.
package cpu_pkg;

  localparam int DATA_W         = 8;
  localparam int NUM_WORDS      = 16;
  localparam int ADDR_W         = 4;
  localparam int ARM_CYCLES     = 2;
  localparam int RELEASE_CYCLES = 2;

  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(NUM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ARM     = 3'd2,
    ST_PROGRAM = 3'd3,
    ST_RELEASE = 3'd4,
    ST_RUN     = 3'd5
  } state_e;

  // Counters stop at NUM_WORDS instead of wrapping.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    if (v >= FULL_C) begin
      return v;
    end else begin
      return v + (ADDR_W+1)'(1);
    end
  endfunction

endpackage

// File: rtl/program_buffer.sv
// Program byte store: synchronous write port, asynchronous read port, no reset.
module program_buffer
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Collects a program byte-stream, then replays it into the CPU RAM through the
// control block's programming strobes while holding the CPU in reset.
module program_loader
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              commit_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              read_ui_in_i,
  input  logic              done_load_i,
  output logic              programming_o,
  output logic              cpu_resetn_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic [ADDR_W:0]   prog_len_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e          state_q, state_d;
  logic [ADDR_W:0] prog_len_q, prog_len_d, words_q, words_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pending_q, pending_d, err_q, err_d;
  logic            in_ready_q, in_ready_d, programming_q, programming_d;
  logic            cpu_resetn_q, cpu_resetn_d, busy_q, busy_d;
  logic            in_prog_s, accept_s, rd_ok_s, done_ok_s;
  logic [DATA_W-1:0] rdata_s;

  program_buffer u_buf (
    .clk_i   (clk_i),
    .we_i    (accept_s),
    .waddr_i (prog_len_q[ADDR_W-1:0]),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata_s)
  );

  assign in_prog_s   = (state_q == ST_PROGRAM);
  assign accept_s    = (state_q == ST_COLLECT) && in_valid_i && in_ready_q;
  assign rd_ok_s     = in_prog_s && read_ui_in_i && (rd_ptr_q < prog_len_q);
  // A done_load must pair with an earlier read_ui_in that has not been matched yet.
  assign done_ok_s   = in_prog_s && done_load_i && pending_q;
  assign load_data_o = (in_prog_s && (rd_ptr_q < prog_len_q)) ? rdata_s : {DATA_W{1'b0}};

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    words_d    = words_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    err_d      = err_q | (read_ui_in_i & ~rd_ok_s) | (done_load_i & ~done_ok_s);
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (start_i) begin
          state_d    = ST_COLLECT;
          prog_len_d = '0;
          words_d    = '0;
          rd_ptr_d   = '0;
          pending_d  = 1'b0;
          err_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_COLLECT: begin
        if (accept_s) begin
          prog_len_d = sat_inc(prog_len_q);
        end else begin
          prog_len_d = prog_len_q;
        end
        if ((prog_len_d == FULL_C) || (commit_i && (prog_len_d != '0))) begin
          state_d = ST_ARM;
          cnt_d   = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_ARM: begin
        if (cnt_q == 2'(ARM_CYCLES - 1)) begin
          state_d = ST_PROGRAM;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_PROGRAM: begin
        rd_ptr_d  = rd_ok_s ? rd_ptr_q + (ADDR_W+1)'(1) : rd_ptr_q;
        pending_d = (pending_q & ~done_ok_s) | rd_ok_s;
        words_d   = done_ok_s ? sat_inc(words_q) : words_q;
        if (done_ok_s && (words_d == prog_len_q)) begin
          state_d = ST_RELEASE;
          cnt_d   = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == 2'(RELEASE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d    = (state_d == ST_COLLECT) && (prog_len_d < FULL_C);
    programming_d = (state_d == ST_PROGRAM);
    busy_d        = !((state_d == ST_IDLE) || (state_d == ST_RUN));
    // During collection the CPU keeps whatever reset level it had on entry.
    case (state_d)
      ST_PROGRAM, ST_RUN: cpu_resetn_d = 1'b1;
      ST_COLLECT:         cpu_resetn_d = cpu_resetn_q;
      default:            cpu_resetn_d = 1'b0;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      prog_len_q    <= '0;
      words_q       <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= 2'd0;
      pending_q     <= 1'b0;
      err_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      programming_q <= 1'b0;
      cpu_resetn_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_len_q    <= prog_len_d;
      words_q       <= words_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
      in_ready_q    <= in_ready_d;
      programming_q <= programming_d;
      cpu_resetn_q  <= cpu_resetn_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign programming_o  = programming_q;
  assign cpu_resetn_o   = cpu_resetn_q;
  assign words_loaded_o = words_q;
  assign prog_len_o     = prog_len_q;
  assign busy_o         = busy_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table plus hand-written
// sequences for full load, read past end and reset during programming.
module tb_program_loader;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0, commit_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       read_ui_in_i = 1'b0, done_load_i = 1'b0;
  logic       in_ready_o, programming_o, cpu_resetn_o, busy_o, err_o;
  logic [7:0] load_data_o;
  logic [4:0] words_loaded_o, prog_len_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .commit_i       (commit_i),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .in_ready_o     (in_ready_o),
    .read_ui_in_i   (read_ui_in_i),
    .done_load_i    (done_load_i),
    .programming_o  (programming_o),
    .cpu_resetn_o   (cpu_resetn_o),
    .load_data_o    (load_data_o),
    .words_loaded_o (words_loaded_o),
    .prog_len_o     (prog_len_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic       st, cm, vl;
    logic [7:0] d;
    logic       rd, dn;
    logic       ir, pg, rn, bz, er;
    logic [4:0] pl, wl;
    logic [7:0] ld;
  } vec_t;

  vec_t vecs [36];

  function automatic vec_t mk(input logic st, cm, vl, input logic [7:0] d, input logic rd, dn,
                              input logic ir, pg, rn, bz, er, input logic [4:0] pl, wl,
                              input logic [7:0] ld);
    vec_t r;
    r.st = st; r.cm = cm; r.vl = vl; r.d = d; r.rd = rd; r.dn = dn;
    r.ir = ir; r.pg = pg; r.rn = rn; r.bz = bz; r.er = er; r.pl = pl; r.wl = wl; r.ld = ld;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then release the inputs.
  task automatic step(input logic st, cm, vl, input logic [7:0] d, input logic rd, dn);
    start_i = st; commit_i = cm; in_valid_i = vl; in_data_i = d;
    read_ui_in_i = rd; done_load_i = dn;
    @(posedge clk);
    #1;
    start_i = O; commit_i = O; in_valid_i = O; in_data_i = 8'h00;
    read_ui_in_i = O; done_load_i = O;
  endtask

  task automatic idle();            step(O, O, O, 8'h00, O, O); endtask
  task automatic rd();              step(O, O, O, 8'h00, I, O); endtask
  task automatic dn();              step(O, O, O, 8'h00, O, I); endtask
  task automatic push(input logic [7:0] b); step(O, O, I, b, O, O); endtask

  task automatic wait_prog(input string nm);
    for (int k = 0; k < 10 && !programming_o; k++) idle();
    chk({nm, "_programming_timeout"}, 8'(programming_o), 8'h01);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"},    8'(in_ready_o),     8'h00);
    chk({nm, "_programming"}, 8'(programming_o),  8'h00);
    chk({nm, "_cpu_resetn"},  8'(cpu_resetn_o),   8'h00);
    chk({nm, "_load_data"},   load_data_o,        8'h00);
    chk({nm, "_words"},       8'(words_loaded_o), 8'h00);
    chk({nm, "_prog_len"},    8'(prog_len_o),     8'h00);
    chk({nm, "_busy"},        8'(busy_o),         8'h00);
    chk({nm, "_err"},         8'(err_o),          8'h00);
  endtask

  initial begin
    int lowcnt;
    //              st cm vl data   rd dn   ir pg rn bz er pl     wl     ld
    vecs[0]  = mk(I, O, O, 8'h00, O, O,  I, O, O, I, O, 5'd0, 5'd0, 8'h00);
    vecs[1]  = mk(O, I, O, 8'h00, O, O,  I, O, O, I, O, 5'd0, 5'd0, 8'h00);
    vecs[2]  = mk(O, O, I, 8'h12, O, O,  I, O, O, I, O, 5'd1, 5'd0, 8'h00);
    vecs[3]  = mk(O, O, I, 8'h23, O, O,  I, O, O, I, O, 5'd2, 5'd0, 8'h00);
    vecs[4]  = mk(O, O, I, 8'h05, O, O,  I, O, O, I, O, 5'd3, 5'd0, 8'h00);
    vecs[5]  = mk(O, I, O, 8'h00, O, O,  O, O, O, I, O, 5'd3, 5'd0, 8'h00);
    vecs[6]  = mk(O, O, O, 8'h00, O, O,  O, O, O, I, O, 5'd3, 5'd0, 8'h00);
    vecs[7]  = mk(O, O, O, 8'h00, O, O,  O, I, I, I, O, 5'd3, 5'd0, 8'h12);
    vecs[8]  = mk(O, O, O, 8'h00, I, O,  O, I, I, I, O, 5'd3, 5'd0, 8'h23);
    vecs[9]  = mk(O, O, O, 8'h00, O, I,  O, I, I, I, O, 5'd3, 5'd1, 8'h23);
    vecs[10] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, O, 5'd3, 5'd1, 8'h05);
    vecs[11] = mk(O, O, O, 8'h00, O, I,  O, I, I, I, O, 5'd3, 5'd2, 8'h05);
    vecs[12] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, O, 5'd3, 5'd2, 8'h00);
    vecs[13] = mk(O, O, O, 8'h00, O, I,  O, O, O, I, O, 5'd3, 5'd3, 8'h00);
    vecs[14] = mk(O, O, O, 8'h00, O, O,  O, O, O, I, O, 5'd3, 5'd3, 8'h00);
    vecs[15] = mk(O, O, O, 8'h00, O, O,  O, O, I, O, O, 5'd3, 5'd3, 8'h00);
    vecs[16] = mk(O, O, O, 8'h00, O, O,  O, O, I, O, O, 5'd3, 5'd3, 8'h00);
    vecs[17] = mk(O, O, O, 8'h00, I, O,  O, O, I, O, I, 5'd3, 5'd3, 8'h00);
    vecs[18] = mk(I, O, O, 8'h00, O, O,  I, O, I, I, O, 5'd0, 5'd0, 8'h00);
    vecs[19] = mk(O, O, I, 8'hA1, O, O,  I, O, I, I, O, 5'd1, 5'd0, 8'h00);
    vecs[20] = mk(O, O, I, 8'hA2, O, O,  I, O, I, I, O, 5'd2, 5'd0, 8'h00);
    vecs[21] = mk(O, O, I, 8'hA3, O, O,  I, O, I, I, O, 5'd3, 5'd0, 8'h00);
    vecs[22] = mk(O, I, I, 8'hA4, O, O,  O, O, O, I, O, 5'd4, 5'd0, 8'h00);
    vecs[23] = mk(O, O, O, 8'h00, O, O,  O, O, O, I, O, 5'd4, 5'd0, 8'h00);
    vecs[24] = mk(O, O, O, 8'h00, O, O,  O, I, I, I, O, 5'd4, 5'd0, 8'hA1);
    vecs[25] = mk(O, O, O, 8'h00, O, I,  O, I, I, I, I, 5'd4, 5'd0, 8'hA1);
    vecs[26] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, I, 5'd4, 5'd0, 8'hA2);
    vecs[27] = mk(O, O, O, 8'h00, O, I,  O, I, I, I, I, 5'd4, 5'd1, 8'hA2);
    vecs[28] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, I, 5'd4, 5'd1, 8'hA3);
    vecs[29] = mk(O, O, O, 8'h00, O, I,  O, I, I, I, I, 5'd4, 5'd2, 8'hA3);
    vecs[30] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, I, 5'd4, 5'd2, 8'hA4);
    vecs[31] = mk(O, O, O, 8'h00, O, I,  O, I, I, I, I, 5'd4, 5'd3, 8'hA4);
    vecs[32] = mk(O, O, O, 8'h00, I, O,  O, I, I, I, I, 5'd4, 5'd3, 8'h00);
    vecs[33] = mk(O, O, O, 8'h00, O, I,  O, O, O, I, I, 5'd4, 5'd4, 8'h00);
    vecs[34] = mk(O, O, O, 8'h00, O, O,  O, O, O, I, I, 5'd4, 5'd4, 8'h00);
    vecs[35] = mk(O, O, O, 8'h00, O, O,  O, O, I, O, I, 5'd4, 5'd4, 8'h00);

    // Reset values.
    idle();
    idle();
    rst_i = O;
    chk_reset_vals("reset");

    // Early commit, empty commit, stray strobes, reload, commit with 4th byte.
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].cm, vecs[i].vl, vecs[i].d, vecs[i].rd, vecs[i].dn);
      chk($sformatf("v%0d_in_ready", i),    8'(in_ready_o),     8'(vecs[i].ir));
      chk($sformatf("v%0d_programming", i), 8'(programming_o),  8'(vecs[i].pg));
      chk($sformatf("v%0d_cpu_resetn", i),  8'(cpu_resetn_o),   8'(vecs[i].rn));
      chk($sformatf("v%0d_busy", i),        8'(busy_o),         8'(vecs[i].bz));
      chk($sformatf("v%0d_err", i),         8'(err_o),          8'(vecs[i].er));
      chk($sformatf("v%0d_prog_len", i),    8'(prog_len_o),     8'(vecs[i].pl));
      chk($sformatf("v%0d_words", i),       8'(words_loaded_o), 8'(vecs[i].wl));
      chk($sformatf("v%0d_load_data", i),   load_data_o,        vecs[i].ld);
    end

    // Full 16-byte load with a control-block model.
    step(I, O, O, 8'h00, O, O);
    chk("full_start_busy", 8'(busy_o), 8'h01);
    chk("full_start_err", 8'(err_o), 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_ready_%0d", i), 8'(in_ready_o), 8'h01);
      push(8'h40 + 8'(i));
    end
    chk("full_ready_drop", 8'(in_ready_o), 8'h00);
    chk("full_prog_len", 8'(prog_len_o), 8'h10);
    lowcnt = 0;
    for (int k = 0; k < 10 && !programming_o; k++) begin
      if (!cpu_resetn_o) lowcnt++;
      idle();
    end
    chk("full_arm_low_cycles", 8'(lowcnt), 8'h02);
    chk("full_programming", 8'(programming_o), 8'h01);
    chk("full_cpu_resetn_prog", 8'(cpu_resetn_o), 8'h01);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_load_data_%0d", i), load_data_o, 8'h40 + 8'(i));
      rd();
      idle();
      idle();
      dn();
      if (i < 15) begin
        idle();
        idle();
      end
    end
    chk("full_words", 8'(words_loaded_o), 8'h10);
    chk("full_release_prog", 8'(programming_o), 8'h00);
    chk("full_release_rstn", 8'(cpu_resetn_o), 8'h00);
    idle();
    chk("full_release2_rstn", 8'(cpu_resetn_o), 8'h00);
    idle();
    chk("full_run_rstn", 8'(cpu_resetn_o), 8'h01);
    chk("full_run_busy", 8'(busy_o), 8'h00);
    chk("full_run_err", 8'(err_o), 8'h00);

    // Read strobe past the end of a 3-byte program.
    step(I, O, O, 8'h00, O, O);
    push(8'h31);
    push(8'h32);
    push(8'h33);
    step(O, I, O, 8'h00, O, O);
    wait_prog("past");
    rd(); dn(); rd(); dn(); rd();
    chk("past_err_before", 8'(err_o), 8'h00);
    rd();
    chk("past_err_after", 8'(err_o), 8'h01);
    chk("past_load_data", load_data_o, 8'h00);
    chk("past_words", 8'(words_loaded_o), 8'h02);
    dn();
    chk("past_release", 8'(programming_o), 8'h00);
    chk("past_words_final", 8'(words_loaded_o), 8'h03);
    idle();
    idle();
    chk("past_run_rstn", 8'(cpu_resetn_o), 8'h01);

    // Reset while programming after 5 committed words.
    step(I, O, O, 8'h00, O, O);
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    step(O, I, O, 8'h00, O, O);
    wait_prog("rstmid");
    for (int i = 0; i < 5; i++) begin
      rd();
      dn();
    end
    chk("rstmid_words", 8'(words_loaded_o), 8'h05);
    dn();
    chk("rstmid_err_set", 8'(err_o), 8'h01);
    rst_i = I;
    idle();
    rst_i = O;
    chk_reset_vals("rstmid");
    idle();
    chk("rstmid_stays_idle", 8'(busy_o), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencer that owns programming of the CPU's 16×8 RAM. It collects a program byte-stream over a valid/ready handshake into an internal buffer. It then holds the CPU in reset, drives the control block's `programming` input, and feeds one byte per `read_ui_in` strobe until every byte is committed by `done_load`. Finally it releases the CPU to run from address 0. It sits between the chip input pins and the control block / bus.

## Interface
- `DATA_W`, 8: byte width of program words and bus.
- `NUM_WORDS`, 16: RAM depth and maximum program length.
- `ADDR_W`, 4: log2(NUM_WORDS).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins collection. Honoured only in IDLE or RUN.
- `commit`  in  1  one-cycle pulse; ends collection early. Ignored if 0 bytes are buffered.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  DATA_W  input byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `read_ui_in`  in  1  control-block strobe (stage T3 in programming mode): bus byte is consumed.
- `done_load`  in  1  control-block strobe (stage T4 in programming mode): RAM write committed.
- `programming`  out  1  drives the control block's `programming` input.
- `cpu_resetn`  out  1  active-low reset to the control block, PC and registers.
- `load_data`  out  DATA_W  byte driven onto the bus during `read_ui_in`.
- `words_loaded`  out  ADDR_W+1  count of committed bytes.
- `prog_len`  out  ADDR_W+1  number of bytes collected.
- `busy`  out  1  high in every state except IDLE and RUN.
- `err`  out  1  sticky protocol error; cleared by `rst` or `start`.

## Operation
- States: IDLE, COLLECT, ARM, PROGRAM, RELEASE, RUN.
- **IDLE**
  - `cpu_resetn`=0.
  - `start` moves to COLLECT.
- **COLLECT**
  - `in_ready`=1 while `prog_len` < NUM_WORDS.
  - On an `in_valid && in_ready` edge: byte written at `prog_len`, `prog_len`++.
  - Moves to ARM when `prog_len` reaches NUM_WORDS, or on `commit` with `prog_len` ≥ 1.
  - If a byte is accepted in the same cycle as `commit`, that byte is included.
- **ARM**
  - `cpu_resetn`=0 for exactly 2 cycles, so the control block sits in its holding stage and PC=0.
  - Then moves to PROGRAM.
- **PROGRAM**
  - `programming`=1, `cpu_resetn`=1.
  - `load_data` = buf[rd_ptr], combinational from the pointer.
  - `rd_ptr`++ on each `read_ui_in` edge.
  - `words_loaded`++ on each `done_load` edge.
  - Moves to RELEASE on the `done_load` that makes `words_loaded` == `prog_len`.
- **RELEASE**
  - `programming`=0, `cpu_resetn`=0 for 2 cycles.
  - Then moves to RUN.
- **RUN**
  - `cpu_resetn`=1; CPU executes from address 0.
  - `start` re-enters COLLECT.
  - Re-entering COLLECT clears `prog_len`, `words_loaded`, pointers and `err`.
- **Errors** (set `err`, no state change):
  - `done_load` without a preceding unmatched `read_ui_in`.
  - `read_ui_in` when `rd_ptr` == `prog_len`; `load_data` then holds 0.
  - `read_ui_in` or `done_load` outside PROGRAM; the strobe is otherwise ignored.
- `in_valid` outside COLLECT: `in_ready`=0, no byte accepted, no error.
- Arithmetic:
  - Counters are ADDR_W+1 bits and saturate at NUM_WORDS.
  - `rd_ptr` is ADDR_W+1 bits; it never wraps.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` 0, `programming` 0, `cpu_resetn` 0.
  - `load_data` 0, `words_loaded` 0, `prog_len` 0.
  - `busy` 0, `err` 0.
- `rst` mid-operation aborts any state within one edge. Buffer contents become don't-care.
- Byte accept latency: accepted on the edge where `in_valid && in_ready`. `prog_len` reflects it the next cycle.
- `in_ready` is a registered function of state and `prog_len`; it does not depend on `in_valid`.
- `start` → `busy`=1 the next cycle.
- Last byte accepted, or `commit` → ARM next cycle → PROGRAM 2 cycles later.
- Each RAM word takes one control-block instruction cycle (~7 clocks).
- Final `done_load` → RELEASE next cycle → RUN 2 cycles later, with `cpu_resetn` rising on RUN entry.
- Strobes are single-cycle. A strobe high for k cycles counts k times.

## Structure
- Shared package `cpu_pkg` holds:
  - state encoding for the six states.
  - `NUM_WORDS`, `DATA_W`, `ADDR_W`.
  - `ARM_CYCLES`=2 and `RELEASE_CYCLES`=2.
- One sub-module, `program_buffer`:
  - NUM_WORDS×DATA_W register file.
  - write port (`we`, `waddr`, `wdata`) and asynchronous read port (`raddr` → `rdata`).
  - no reset on storage.
- FSM, counters and error logic live in `program_loader`.

## Test plan
- **Full load:** `start`, then 16 bytes 0x40..0x4F → `in_ready` drops after the 16th byte. `cpu_resetn` is low 2 cycles, then `programming`=1. A control-block model issuing 16 `read_ui_in`/`done_load` pairs sees `load_data` = 0x40..0x4F in order. `words_loaded`=16, then RUN with `cpu_resetn`=1.
- **Early commit:** 3 bytes 0x12,0x23,0x05, then `commit` → `prog_len`=3. Exactly 3 strobe pairs are consumed, then RELEASE/RUN. `commit` in the same cycle as a 4th accepted byte gives `prog_len`=4.
- **Empty commit:** `commit` with 0 bytes → stays in COLLECT, `err`=0.
- **Protocol error:** during PROGRAM, `done_load` with no prior `read_ui_in` → `err`=1 and `words_loaded` unchanged. A 4th `read_ui_in` after `prog_len`=3 → `err`=1 and `load_data`=0.
- **Reset mid-PROGRAM:** `rst` after 5 committed words → next cycle IDLE with every output at its reset value.
- **Reload from RUN:** `start` while in RUN → COLLECT, counters and `err` cleared, `cpu_resetn`=1 until ARM.
